ccip_host_mem_responder: RTL and testbench

- Synthesizable CCI-P host-memory responder, the shared-memory end of the AFU request interface.
- Accepts read requests on c0 and write requests on c1 of af2cp_sTx, and returns read and write responses on cp2af_sRx.
- Holds a small line-addressed memory with a backdoor load/inspect port. Benches use it to run join/filter AFUs without the FIU.

---
 rtl/ccip_host_mem_responder_if.sv | 87 ++++++++
 rtl/ccip_host_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_ccip_host_mem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccip_host_mem_responder_if.sv
// CCI-P request/response types and the AFU <-> host-memory interface bundle.
// Types only; no logic or latency here.
// Flow control is carried by c0TxAlmFull/c1TxAlmFull inside t_if_ccip_Rx.
package ccip_hmr_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1,
                            eREQ_WRPUSH_I = 4'h2, eREQ_WRFENCE  = 4'h4} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {t_ccip_c0_ReqMemHdr hdr; logic valid;} t_if_ccip_c0_Tx;
  typedef struct packed {t_ccip_c1_ReqMemHdr hdr; t_ccip_clData data; logic valid;} t_if_ccip_c1_Tx;
  typedef struct packed {logic [8:0] tid; logic [63:0] data; logic mmioRdValid;} t_if_ccip_c2_Tx;
  typedef struct packed {t_if_ccip_c0_Tx c0; t_if_ccip_c1_Tx c1; t_if_ccip_c2_Tx c2;} t_if_ccip_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {t_ccip_c1_RspMemHdr hdr; logic rspValid;} t_if_ccip_c1_Rx;
  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

interface ccip_host_mem_responder_if;
  import ccip_hmr_pkg::*;
  t_if_ccip_Tx af2cp_sTx;
  t_if_ccip_Rx cp2af_sRx;
  modport master (output af2cp_sTx, input cp2af_sRx);
  modport slave  (input af2cp_sTx, output cp2af_sRx);
endinterface

// File: rtl/ccip_host_mem_responder.sv
// CCI-P host-memory responder: line memory answering AFU reads (c0) and writes (c1) in order.
// Latency: read response RD_LATENCY cycles after accept, write ack WR_LATENCY cycles after accept.
// Backpressure: cN TxAlmFull at ALM_FULL_THRESH occupancy; requests into a full queue are dropped.
module ccip_hmr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dat,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_store [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // entry storage; no reset needed since occupancy gates what is visible
  always_ff @(posedge clk) begin
    if (i_push) r_store[r_wr_ptr] <= i_dat;
  end

  // pointers and occupancy; caller never pushes a full queue without popping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_dat   = r_store[r_rd_ptr];
  assign o_count = r_count;
endmodule

module ccip_host_mem_responder
  import ccip_hmr_pkg::*;
#(
  parameter int MEM_LINES_LOG2  = 7,
  parameter int RD_LATENCY      = 4,
  parameter int WR_LATENCY      = 2,
  parameter int Q_DEPTH         = 8,
  parameter int ALM_FULL_THRESH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  ccip_host_mem_responder_if.slave  ccip,
  input  t_ccip_clAddr              base_cl_addr,
  input  logic                      bd_wr_en,
  input  logic [MEM_LINES_LOG2-1:0] bd_idx,
  input  logic [511:0]              bd_wdata,
  output logic [511:0]              bd_rdata,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count,
  output logic [2:0]                err_sticky
);
  localparam int LINES = 1 << MEM_LINES_LOG2;
  localparam int QW    = $clog2(Q_DEPTH) + 1;

  typedef struct packed {logic [15:0] due; t_ccip_mdata mdata; t_ccip_clData data;} t_rd_ent;
  typedef struct packed {logic [15:0] due; t_ccip_mdata mdata;} t_wr_ent;

  logic [511:0] r_mem [LINES];
  logic [511:0] r_bd_rdata;
  logic [15:0]  r_now;
  logic [31:0]  r_rd_count, r_wr_count;
  logic [2:0]   r_err;
  logic         r_c0_almfull, r_c1_almfull;

  t_if_ccip_Tx  w_tx;
  t_if_ccip_Rx  w_rx;
  logic [42:0]  w_rd_diff, w_wr_diff;
  logic         w_rd_oor, w_wr_oor, w_rd_bad, w_wr_bad;
  logic [MEM_LINES_LOG2-1:0] w_rd_idx, w_wr_idx;
  logic         w_rd_acc, w_wr_acc, w_rd_pop, w_wr_pop;
  logic [QW-1:0] w_rd_cnt, w_wr_cnt, w_rd_cnt_nxt, w_wr_cnt_nxt;
  t_rd_ent      w_rd_push, w_rd_head;
  t_wr_ent      w_wr_push, w_wr_head;
  logic         w_unused;

  assign w_tx = ccip.af2cp_sTx;
  assign w_unused = ^{w_tx.c2, w_tx.c0.hdr.vc_sel, w_tx.c0.hdr.rsvd1, w_tx.c0.hdr.rsvd0,
                      w_tx.c1.hdr.rsvd2, w_tx.c1.hdr.vc_sel, w_tx.c1.hdr.rsvd1, w_tx.c1.hdr.rsvd0};

  // Address translation: an extra top bit catches addresses below the base.
  assign w_rd_diff = {1'b0, w_tx.c0.hdr.address} - {1'b0, base_cl_addr};
  assign w_wr_diff = {1'b0, w_tx.c1.hdr.address} - {1'b0, base_cl_addr};
  assign w_rd_oor  = w_rd_diff[42] | (|w_rd_diff[41:MEM_LINES_LOG2]);
  assign w_wr_oor  = w_wr_diff[42] | (|w_wr_diff[41:MEM_LINES_LOG2]);
  assign w_rd_idx  = w_rd_diff[MEM_LINES_LOG2-1:0];
  assign w_wr_idx  = w_wr_diff[MEM_LINES_LOG2-1:0];

  assign w_rd_bad = ((w_tx.c0.hdr.req_type != eREQ_RDLINE_I) && (w_tx.c0.hdr.req_type != eREQ_RDLINE_S))
                    || (w_tx.c0.hdr.cl_len != eCL_LEN_1);
  assign w_wr_bad = ((w_tx.c1.hdr.req_type != eREQ_WRLINE_I) && (w_tx.c1.hdr.req_type != eREQ_WRLINE_M))
                    || !w_tx.c1.hdr.sop || (w_tx.c1.hdr.cl_len != eCL_LEN_1);

  // Head pops once its due stamp is reached; wrap-safe compare on the 16-bit time base.
  assign w_rd_pop = !reset && (w_rd_cnt != '0) && ((r_now - w_rd_head.due) < 16'h8000);
  assign w_wr_pop = !reset && (w_wr_cnt != '0) && ((r_now - w_wr_head.due) < 16'h8000);
  // A full queue still accepts when its head leaves in the same cycle.
  assign w_rd_acc = !reset && w_tx.c0.valid && ((w_rd_cnt != QW'(Q_DEPTH)) || w_rd_pop);
  assign w_wr_acc = !reset && w_tx.c1.valid && ((w_wr_cnt != QW'(Q_DEPTH)) || w_wr_pop);
  assign w_rd_cnt_nxt = w_rd_cnt + QW'(w_rd_acc) - QW'(w_rd_pop);
  assign w_wr_cnt_nxt = w_wr_cnt + QW'(w_wr_acc) - QW'(w_wr_pop);

  // Read data is captured at acceptance, so a same-cycle write to that line is not seen.
  assign w_rd_push.due   = r_now + 16'(RD_LATENCY);
  assign w_rd_push.mdata = w_tx.c0.hdr.mdata;
  assign w_rd_push.data  = w_rd_oor ? '0 : r_mem[w_rd_idx];
  assign w_wr_push.due   = r_now + 16'(WR_LATENCY);
  assign w_wr_push.mdata = w_tx.c1.hdr.mdata;

  ccip_hmr_fifo #(.W($bits(t_rd_ent)), .DEPTH(Q_DEPTH)) u_rd_q (
    .clk(clk), .reset(reset), .i_push(w_rd_acc), .i_dat(w_rd_push),
    .i_pop(w_rd_pop), .o_dat(w_rd_head), .o_count(w_rd_cnt));
  ccip_hmr_fifo #(.W($bits(t_wr_ent)), .DEPTH(Q_DEPTH)) u_wr_q (
    .clk(clk), .reset(reset), .i_push(w_wr_acc), .i_dat(w_wr_push),
    .i_pop(w_wr_pop), .o_dat(w_wr_head), .o_count(w_wr_cnt));

  // line writes; the AFU write is applied last so it wins an index collision with the backdoor
  always_ff @(posedge clk) begin
    if (bd_wr_en) r_mem[bd_idx] <= bd_wdata;
    if (w_wr_acc && !w_wr_oor) r_mem[w_wr_idx] <= w_tx.c1.data;
  end

  // time base, backdoor read port, counters, sticky errors and almost-full flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_now        <= '0;
      r_bd_rdata   <= '0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
      r_err        <= '0;
      r_c0_almfull <= 1'b0;
      r_c1_almfull <= 1'b0;
    end else begin
      r_now      <= r_now + 16'd1;
      r_bd_rdata <= r_mem[bd_idx];
      if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
      if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
      if ((w_tx.c0.valid && w_rd_oor) || (w_tx.c1.valid && w_wr_oor)) r_err[0] <= 1'b1;
      if ((w_tx.c0.valid && !w_rd_acc) || (w_tx.c1.valid && !w_wr_acc)) r_err[1] <= 1'b1;
      if ((w_tx.c0.valid && w_rd_bad) || (w_tx.c1.valid && w_wr_bad)) r_err[2] <= 1'b1;
      r_c0_almfull <= (w_rd_cnt_nxt >= QW'(ALM_FULL_THRESH));
      r_c1_almfull <= (w_wr_cnt_nxt >= QW'(ALM_FULL_THRESH));
    end
  end

  // response formatting straight from the queue heads; MMIO fields stay idle
  always_comb begin
    w_rx = '0;
    w_rx.c0TxAlmFull        = r_c0_almfull;
    w_rx.c1TxAlmFull        = r_c1_almfull;
    w_rx.c0.rspValid        = w_rd_pop;
    w_rx.c0.hdr.resp_type   = eRSP_RDLINE;
    w_rx.c0.hdr.vc_used     = eVC_VL0;
    w_rx.c0.hdr.mdata       = w_rd_head.mdata;
    w_rx.c0.data            = w_rd_head.data;
    w_rx.c1.rspValid        = w_wr_pop;
    w_rx.c1.hdr.resp_type   = eRSP_WRLINE;
    w_rx.c1.hdr.vc_used     = eVC_VL0;
    w_rx.c1.hdr.mdata       = w_wr_head.mdata;
  end

  assign ccip.cp2af_sRx = w_rx;
  assign bd_rdata   = r_bd_rdata;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;
  assign err_sticky = r_err;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Bench for ccip_host_mem_responder: a default build and an RD_LATENCY=20 build.
// Expected responses are queued at issue time and matched by a negedge monitor.
// Directed stimulus only; all expected data is computed here.
module tb_ccip_host_mem_responder;
  import ccip_hmr_pkg::*;

  typedef struct {logic [15:0] mdata; logic [511:0] data; int due;} exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_a0[$], exp_a1[$], exp_b0[$], exp_b1[$];

  t_ccip_clAddr base = 42'h1000;
  logic         bd_wr_en;
  logic [6:0]   bd_idx;
  logic [511:0] bd_wdata;
  logic [511:0] bd_rdata_a, bd_rdata_b;
  logic [31:0]  rd_count_a, wr_count_a, rd_count_b, wr_count_b;
  logic [2:0]   err_a, err_b;

  ccip_host_mem_responder_if if_a();
  ccip_host_mem_responder_if if_b();

  ccip_host_mem_responder u_dut_a (
    .clk(clk), .reset(rst_a), .ccip(if_a.slave), .base_cl_addr(base),
    .bd_wr_en(bd_wr_en), .bd_idx(bd_idx), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata_a),
    .rd_count(rd_count_a), .wr_count(wr_count_a), .err_sticky(err_a));

  ccip_host_mem_responder #(.RD_LATENCY(20)) u_dut_b (
    .clk(clk), .reset(rst_b), .ccip(if_b.slave), .base_cl_addr(base),
    .bd_wr_en(1'b0), .bd_idx(7'd0), .bd_wdata(512'd0), .bd_rdata(bd_rdata_b),
    .rd_count(rd_count_b), .wr_count(wr_count_b), .err_sticky(err_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {64{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic clr();
    if_a.af2cp_sTx = '0;
    if_b.af2cp_sTx = '0;
  endtask

  task automatic rd(input bit b, input logic [41:0] addr, input logic [15:0] md,
                    input logic [511:0] exp_d, input t_ccip_clLen len, input bit expect_rsp);
    t_ccip_c0_ReqMemHdr h;
    exp_t e;
    h = '0;
    h.req_type = eREQ_RDLINE_S;
    h.cl_len = len;
    h.address = addr;
    h.mdata = md;
    e.mdata = md;
    e.data = exp_d;
    e.due = cyc + (b ? 20 : 4);
    if (b) begin
      if_b.af2cp_sTx.c0.hdr = h;
      if_b.af2cp_sTx.c0.valid = 1'b1;
      if (expect_rsp) exp_b0.push_back(e);
    end else begin
      if_a.af2cp_sTx.c0.hdr = h;
      if_a.af2cp_sTx.c0.valid = 1'b1;
      if (expect_rsp) exp_a0.push_back(e);
    end
  endtask

  task automatic wr(input logic [41:0] addr, input logic [15:0] md, input logic [511:0] d);
    t_ccip_c1_ReqMemHdr h;
    exp_t e;
    h = '0;
    h.req_type = eREQ_WRLINE_I;
    h.sop = 1'b1;
    h.cl_len = eCL_LEN_1;
    h.address = addr;
    h.mdata = md;
    e.mdata = md;
    e.data = '0;
    e.due = cyc + 2;
    if_a.af2cp_sTx.c1.hdr = h;
    if_a.af2cp_sTx.c1.data = d;
    if_a.af2cp_sTx.c1.valid = 1'b1;
    exp_a1.push_back(e);
  endtask

  task automatic mon_c0(input bit b, input t_if_ccip_c0_Rx rx);
    exp_t e;
    bit have;
    have = 1'b0;
    if (b) begin
      if (exp_b0.size() > 0) begin e = exp_b0.pop_front(); have = 1'b1; end
    end else begin
      if (exp_a0.size() > 0) begin e = exp_a0.pop_front(); have = 1'b1; end
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s_c0_unexpected got mdata=%h at cycle %0d, want no response", b ? "b" : "a",
               rx.hdr.mdata, cyc);
    end else if (rx.hdr.mdata !== e.mdata || rx.data !== e.data || cyc != e.due ||
                 rx.hdr.resp_type !== eRSP_RDLINE || rx.hdr.cl_num !== 2'd0 ||
                 rx.hdr.vc_used !== eVC_VL0 || rx.mmioRdValid !== 1'b0 || rx.mmioWrValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_c0_rsp got mdata=%h cyc=%0d data=%h type=%h want mdata=%h cyc=%0d data=%h",
               b ? "b" : "a", rx.hdr.mdata, cyc, rx.data[63:0], rx.hdr.resp_type,
               e.mdata, e.due, e.data[63:0]);
    end
  endtask

  task automatic mon_c1(input bit b, input t_if_ccip_c1_Rx rx);
    exp_t e;
    bit have;
    have = 1'b0;
    if (b) begin
      if (exp_b1.size() > 0) begin e = exp_b1.pop_front(); have = 1'b1; end
    end else begin
      if (exp_a1.size() > 0) begin e = exp_a1.pop_front(); have = 1'b1; end
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s_c1_unexpected got mdata=%h at cycle %0d, want no response", b ? "b" : "a",
               rx.hdr.mdata, cyc);
    end else if (rx.hdr.mdata !== e.mdata || cyc != e.due || rx.hdr.resp_type !== eRSP_WRLINE ||
                 rx.hdr.format !== 1'b0 || rx.hdr.cl_num !== 2'd0) begin
      errors++;
      $display("FAIL %s_c1_rsp got mdata=%h cyc=%0d type=%h want mdata=%h cyc=%0d",
               b ? "b" : "a", rx.hdr.mdata, cyc, rx.hdr.resp_type, e.mdata, e.due);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (if_a.cp2af_sRx.c0.rspValid) mon_c0(1'b0, if_a.cp2af_sRx.c0);
      if (if_a.cp2af_sRx.c1.rspValid) mon_c1(1'b0, if_a.cp2af_sRx.c1);
      if (if_b.cp2af_sRx.c0.rspValid) mon_c0(1'b1, if_b.cp2af_sRx.c0);
      if (if_b.cp2af_sRx.c1.rspValid) mon_c1(1'b1, if_b.cp2af_sRx.c1);
    end
  endtask

  logic [511:0] dead, new3, bd_x, afu_y;

  initial begin
    dead  = {16{32'hDEADBEEF}};
    new3  = {64{8'h5C}};
    bd_x  = {64{8'h11}};
    afu_y = {64{8'h77}};
    rst_a = 1'b1;
    rst_b = 1'b1;
    bd_wr_en = 1'b0;
    bd_idx = '0;
    bd_wdata = '0;
    clr();
    fork monitor(); join_none

    // reset state of both builds
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_c0_valid", 512'(if_a.cp2af_sRx.c0.rspValid), 512'd0);
    chk("a_rst_c1_valid", 512'(if_a.cp2af_sRx.c1.rspValid), 512'd0);
    chk("a_rst_almfull", 512'({if_a.cp2af_sRx.c0TxAlmFull, if_a.cp2af_sRx.c1TxAlmFull}), 512'd0);
    chk("a_rst_counts", 512'({rd_count_a, wr_count_a}), 512'd0);
    chk("a_rst_err", 512'(err_a), 512'd0);
    chk("a_rst_bd_rdata", bd_rdata_a, 512'd0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // backdoor load lines 0..7
    for (int i = 0; i < 8; i++) begin
      bd_wr_en = 1'b1;
      bd_idx = 7'(i);
      bd_wdata = pat(i);
      tick();
    end
    bd_wr_en = 1'b0;
    bd_idx = 7'd2;
    tick();
    @(negedge clk);
    chk("a_bd_rdata_idx2", bd_rdata_a, pat(2));

    // single read, latency 4
    tick();
    rd(1'b0, 42'h1002, 16'd5, pat(2), eCL_LEN_1, 1'b1);
    tick();
    clr();
    repeat (8) tick();

    // eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      rd(1'b0, 42'h1000 + 42'(i), 16'h10 + 16'(i), pat(i), eCL_LEN_1, 1'b1);
      tick();
    end
    clr();
    repeat (10) tick();

    // write, ack latency 2, visible through the backdoor
    wr(42'h1010, 16'd9, dead);
    tick();
    clr();
    bd_idx = 7'd16;
    tick();
    tick();
    @(negedge clk);
    chk("a_bd_after_write", bd_rdata_a, dead);
    chk("a_wr_count_1", 512'(wr_count_a), 512'd1);
    chk("a_rd_count_9", 512'(rd_count_a), 512'd9);
    chk("a_err_clean", 512'(err_a), 512'd0);

    // out-of-range read below base and write past the top
    tick();
    rd(1'b0, 42'h0FFF, 16'h21, 512'd0, eCL_LEN_1, 1'b1);
    wr(42'h1080, 16'h22, {16{32'hBAD0BAD0}});
    tick();
    clr();
    bd_idx = 7'd0;
    tick();
    tick();
    @(negedge clk);
    chk("a_err_oor", 512'(err_a), 512'(3'b001));
    chk("a_oor_mem_unchanged", bd_rdata_a, pat(0));

    // same-cycle read and write to line 3, then a later read
    tick();
    rd(1'b0, 42'h1003, 16'h31, pat(3), eCL_LEN_1, 1'b1);
    wr(42'h1003, 16'h32, new3);
    tick();
    clr();
    rd(1'b0, 42'h1003, 16'h33, new3, eCL_LEN_1, 1'b1);
    tick();
    clr();

    // backdoor and AFU write collide on line 5
    bd_wr_en = 1'b1;
    bd_idx = 7'd5;
    bd_wdata = bd_x;
    wr(42'h1005, 16'h34, afu_y);
    tick();
    clr();
    bd_wr_en = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("a_collision_afu_wins", bd_rdata_a, afu_y);

    // unsupported length is flagged but still answered as a single line
    tick();
    rd(1'b0, 42'h1001, 16'h35, pat(1), eCL_LEN_2, 1'b1);
    tick();
    clr();
    repeat (10) tick();
    @(negedge clk);
    chk("a_err_unsupported", 512'(err_a), 512'(3'b101));
    chk("a_rd_count_final", 512'(rd_count_a), 512'd13);
    chk("a_wr_count_final", 512'(wr_count_a), 512'd4);
    tick();

    // long-latency build: nine reads into an eight-entry queue
    for (int i = 0; i < 9; i++) begin
      rd(1'b1, 42'h1000 + 42'(i), 16'h40 + 16'(i), 512'd0, eCL_LEN_1, i < 8);
      @(negedge clk);
      chk($sformatf("b_almfull_rd%0d", i), 512'(if_b.cp2af_sRx.c0TxAlmFull), 512'(i >= 6));
      tick();
    end
    clr();
    @(negedge clk);
    chk("b_almfull_held", 512'(if_b.cp2af_sRx.c0TxAlmFull), 512'd1);
    chk("b_err_overflow", 512'(err_b), 512'(3'b010));
    chk("b_rd_count_8", 512'(rd_count_b), 512'd8);

    // reset mid-burst discards everything queued
    tick();
    tick();
    rst_b = 1'b1;
    exp_b0.delete();
    tick();
    tick();
    @(negedge clk);
    chk("b_rst_c0_valid", 512'(if_b.cp2af_sRx.c0.rspValid), 512'd0);
    chk("b_rst_almfull", 512'({if_b.cp2af_sRx.c0TxAlmFull, if_b.cp2af_sRx.c1TxAlmFull}), 512'd0);
    chk("b_rst_counts", 512'({rd_count_b, wr_count_b}), 512'd0);
    chk("b_rst_err", 512'(err_b), 512'd0);
    chk("b_rst_bd_rdata", bd_rdata_b, 512'd0);
    tick();
    rst_b = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    chk("b_post_rst_counts", 512'({rd_count_b, wr_count_b}), 512'd0);

    // bounded drain, then report anything still outstanding
    for (int i = 0; i < 50; i++) begin
      if (exp_a0.size() == 0 && exp_a1.size() == 0 && exp_b0.size() == 0 && exp_b1.size() == 0) break;
      tick();
    end
    while (exp_a0.size() > 0) begin
      exp_t e;
      e = exp_a0.pop_front();
      checks++;
      errors++;
      $display("FAIL a_c0_missing mdata=%h due=%0d got no response", e.mdata, e.due);
    end
    while (exp_a1.size() > 0) begin
      exp_t e;
      e = exp_a1.pop_front();
      checks++;
      errors++;
      $display("FAIL a_c1_missing mdata=%h due=%0d got no response", e.mdata, e.due);
    end
    while (exp_b0.size() > 0) begin
      exp_t e;
      e = exp_b0.pop_front();
      checks++;
      errors++;
      $display("FAIL b_c0_missing mdata=%h due=%0d got no response", e.mdata, e.due);
    end
    while (exp_b1.size() > 0) begin
      exp_t e;
      e = exp_b1.pop_front();
      checks++;
      errors++;
      $display("FAIL b_c1_missing mdata=%h due=%0d got no response", e.mdata, e.due);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
